lc3_control_unit: RTL and testbench

Moore-style instruction sequencer for the 16-bit LC-3 subset datapath. It drives every load, gate and mux-select input of the datapath through fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE. It also generates the active-low SRAM strobes with a parameterised wait-state count, and sits between the top level (Run/Continue switches), the datapath and the memory interface.

---
 rtl/lc3_control_unit.sv | 132 +++++++++++++
 tb/tb_lc3_control_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_unit.sv
// Moore sequencer for the LC-3 subset datapath: fetch/decode/execute control,
// plus SRAM strobes with a MEM_WAIT-cycle access window.
module lc3_control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
        S04, S21, S06, S07, S25, S27, S23, S16, SP1, SP2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       led_q, led_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= HALTED;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    // Counter defaults to 0 so it is cleared whenever a wait state is entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            HALTED: if (Run) state_d = S18;
            S18:    state_d = S33;
            S33:    if (cnt_q == WAIT_LAST) state_d = S35; else cnt_d = cnt_q + 3'd1;
            S35:    state_d = S32;
            S32: begin
                unique case (Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
                    4'b1101: state_d = SP1;
                    default: state_d = S18;
                endcase
            end
            S01, S05, S09, S22, S12, S21, S27: state_d = S18;
            S00:    state_d = BEN ? S22 : S18;
            S04:    state_d = S21;
            S06:    state_d = S25;
            S07:    state_d = S23;
            S25:    if (cnt_q == WAIT_LAST) state_d = S27; else cnt_d = cnt_q + 3'd1;
            S23:    state_d = S16;
            S16:    if (cnt_q == WAIT_LAST) state_d = S18; else cnt_d = cnt_q + 3'd1;
            SP1:    if (Continue) state_d = SP2;
            SP2:    if (!Continue) state_d = S18;
            default: state_d = HALTED;
        endcase
        led_d = (state_d == SP1) && (state_q != SP1);
    end

    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'd0; ADDR2MUX = 2'd0; ALUK = 2'd0;
        DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0; MIO_EN = 1'b0;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        unique case (state_q)
            S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S33, S25: begin MIO_EN = 1'b1; Mem_OE = 1'b0; LD_MDR = 1'b1; end
            S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            S32: LD_BEN = 1'b1;
            S01, S05, S09: begin
                SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1;
                DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state_q == S01) ? 2'd0 : (state_q == S05) ? 2'd1 : 2'd2;
            end
            S22: begin ADDR2MUX = 2'd2; PCMUX = 2'd2; LD_PC = 1'b1; end
            S12: begin SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'd2; LD_PC = 1'b1; end
            S04: begin GatePC = 1'b1; LD_REG = 1'b1; end
            S21: begin ADDR2MUX = 2'd3; PCMUX = 2'd2; LD_PC = 1'b1; end
            S06, S07: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'd1;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S27: begin GateMDR = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            // Store data reaches MDR through the address adder (SR + 0).
            S23: begin ADDR1MUX = 1'b1; GateMARMUX = 1'b1; LD_MDR = 1'b1; end
            S16: Mem_WE = 1'b0;
            SP1: LD_LED = led_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Bench for lc3_control_unit: per-instruction expected control-word scripts
// built from the state table, checked every cycle on MEM_WAIT=2 and =3 instances.
module tb_lc3_control_unit;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
    } ctl_t;

    typedef struct {
        ctl_t       e;
        logic       cont, run, rst, ir5, ben;
        logic [3:0] op;
    } step_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset;
    logic       run_i [2], cont_i [2], ir5_i [2], ben_i [2];
    logic [3:0] op_i [2];
    ctl_t       d2, d3;
    step_t      q [$];
    int         total = 0, bad = 0, cyc = 0, mark = 0;
    logic       chk_en = 1'b0;
    logic [3:0] cur_op;
    logic       cur_ir5, cur_ben;

    lc3_control_unit #(.MEM_WAIT(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Run(run_i[0]), .Continue(cont_i[0]),
        .Opcode(op_i[0]), .IR_5(ir5_i[0]), .BEN(ben_i[0]),
        .LD_MAR(d2.ld_mar), .LD_MDR(d2.ld_mdr), .LD_IR(d2.ld_ir), .LD_BEN(d2.ld_ben),
        .LD_CC(d2.ld_cc), .LD_REG(d2.ld_reg), .LD_PC(d2.ld_pc), .LD_LED(d2.ld_led),
        .GatePC(d2.gate_pc), .GateMDR(d2.gate_mdr), .GateALU(d2.gate_alu),
        .GateMARMUX(d2.gate_marmux), .PCMUX(d2.pcmux), .ADDR2MUX(d2.addr2mux),
        .ALUK(d2.aluk), .DRMUX(d2.drmux), .SR1MUX(d2.sr1mux), .SR2MUX(d2.sr2mux),
        .ADDR1MUX(d2.addr1mux), .MIO_EN(d2.mio_en), .Mem_OE(d2.mem_oe), .Mem_WE(d2.mem_we)
    );

    lc3_control_unit #(.MEM_WAIT(3)) dut3 (
        .Clk(Clk), .Reset(Reset), .Run(run_i[1]), .Continue(cont_i[1]),
        .Opcode(op_i[1]), .IR_5(ir5_i[1]), .BEN(ben_i[1]),
        .LD_MAR(d3.ld_mar), .LD_MDR(d3.ld_mdr), .LD_IR(d3.ld_ir), .LD_BEN(d3.ld_ben),
        .LD_CC(d3.ld_cc), .LD_REG(d3.ld_reg), .LD_PC(d3.ld_pc), .LD_LED(d3.ld_led),
        .GatePC(d3.gate_pc), .GateMDR(d3.gate_mdr), .GateALU(d3.gate_alu),
        .GateMARMUX(d3.gate_marmux), .PCMUX(d3.pcmux), .ADDR2MUX(d3.addr2mux),
        .ALUK(d3.aluk), .DRMUX(d3.drmux), .SR1MUX(d3.sr1mux), .SR2MUX(d3.sr2mux),
        .ADDR1MUX(d3.addr1mux), .MIO_EN(d3.mio_en), .Mem_OE(d3.mem_oe), .Mem_WE(d3.mem_we)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
        end
    endtask

    // Structural rules that must hold on every cycle for both instances.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("gates2", 32'($countones({d2.gate_pc, d2.gate_mdr, d2.gate_alu, d2.gate_marmux}) <= 1), 32'd1);
            check("gates3", 32'($countones({d3.gate_pc, d3.gate_mdr, d3.gate_alu, d3.gate_marmux}) <= 1), 32'd1);
            check("strobes2", 32'(d2.mem_oe | d2.mem_we), 32'd1);
            check("strobes3", 32'(d3.mem_oe | d3.mem_we), 32'd1);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    // Control word the state table lists for a named state.
    function automatic ctl_t row(input string s, input logic ir5);
        ctl_t c;
        c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        case (s)
            "S18": begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
            "RD":  begin c.mio_en = 1; c.mem_oe = 0; c.ld_mdr = 1; end
            "S35": begin c.gate_mdr = 1; c.ld_ir = 1; end
            "S32": c.ld_ben = 1;
            "S01", "S05", "S09": begin
                c.sr1mux = 1; c.sr2mux = ir5; c.gate_alu = 1; c.drmux = 1;
                c.ld_reg = 1; c.ld_cc = 1;
                c.aluk = (s == "S01") ? 2'd0 : (s == "S05") ? 2'd1 : 2'd2;
            end
            "S22": begin c.addr2mux = 2; c.pcmux = 2; c.ld_pc = 1; end
            "S12": begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2; c.ld_pc = 1; end
            "S04": begin c.gate_pc = 1; c.ld_reg = 1; end
            "S21": begin c.addr2mux = 3; c.pcmux = 2; c.ld_pc = 1; end
            "S06", "S07": begin
                c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 1; c.gate_marmux = 1; c.ld_mar = 1;
            end
            "S27": begin c.gate_mdr = 1; c.drmux = 1; c.ld_reg = 1; c.ld_cc = 1; end
            "S23": begin c.addr1mux = 1; c.gate_marmux = 1; c.ld_mdr = 1; end
            "WR":  c.mem_we = 0;
            "LED": c.ld_led = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic push(input string s, input logic cont, input logic run, input logic rst);
        step_t t;
        t.e = row(s, cur_ir5);
        t.cont = cont; t.run = run; t.rst = rst;
        t.op = cur_op; t.ir5 = cur_ir5; t.ben = cur_ben;
        q.push_back(t);
    endtask

    task automatic halted(input int n);
        repeat (n) push("HALT", rb(), 1'b0, 1'b0);
        push("HALT", rb(), 1'b1, 1'b0);
    endtask

    task automatic end_seq();
        push("S18", rb(), rb(), 1'b1);
        push("HALT", rb(), 1'b0, 1'b0);
    endtask

    task automatic add_instr(input int m, input logic [3:0] op, input logic ir5,
                             input logic ben, input int hold1, input int hold2);
        cur_op = op; cur_ir5 = ir5; cur_ben = ben;
        push("S18", rb(), rb(), 1'b0);
        repeat (m) push("RD", rb(), rb(), 1'b0);
        push("S35", rb(), rb(), 1'b0);
        push("S32", rb(), rb(), 1'b0);
        case (op)
            4'b0001: push("S01", rb(), rb(), 1'b0);
            4'b0101: push("S05", rb(), rb(), 1'b0);
            4'b1001: push("S09", rb(), rb(), 1'b0);
            4'b0000: begin
                push("S00", rb(), rb(), 1'b0);
                if (ben) push("S22", rb(), rb(), 1'b0);
            end
            4'b1100: push("S12", rb(), rb(), 1'b0);
            4'b0100: begin push("S04", rb(), rb(), 1'b0); push("S21", rb(), rb(), 1'b0); end
            4'b0110: begin
                push("S06", rb(), rb(), 1'b0);
                mark = q.size();
                repeat (m) push("RD", rb(), rb(), 1'b0);
                push("S27", rb(), rb(), 1'b0);
            end
            4'b0111: begin
                push("S07", rb(), rb(), 1'b0);
                push("S23", rb(), rb(), 1'b0);
                repeat (m) push("WR", rb(), rb(), 1'b0);
            end
            4'b1101: begin
                push("LED", 1'b0, rb(), 1'b0);
                repeat (hold1) push("SP1", 1'b0, rb(), 1'b0);
                push("SP1", 1'b1, rb(), 1'b0);
                repeat (hold2) push("SP2", 1'b1, rb(), 1'b0);
                push("SP2", 1'b0, rb(), 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic play(input int sel, output int period, output int oe_low,
                        output int we_low, output int led_cnt);
        step_t t;
        ctl_t  cur;
        int    last_fetch;
        last_fetch = -1; period = 0; oe_low = 0; we_low = 0; led_cnt = 0;
        while (q.size() > 0) begin
            t = q.pop_front();
            Reset = t.rst;
            run_i[sel] = t.run; cont_i[sel] = t.cont;
            op_i[sel] = t.op; ir5_i[sel] = t.ir5; ben_i[sel] = t.ben;
            cur = (sel != 0) ? d3 : d2;
            check(sel != 0 ? "ctl_mw3" : "ctl_mw2", 32'(cur), 32'(t.e));
            if (cur.gate_pc && cur.ld_mar && cur.ld_pc) begin
                if (last_fetch >= 0) period = cyc - last_fetch;
                last_fetch = cyc;
            end
            if (!cur.mem_oe) oe_low++;
            if (!cur.mem_we) we_low++;
            if (cur.ld_led) led_cnt++;
            @(posedge Clk); #1;
            cyc++;
        end
        Reset = 1'b0;
        run_i[sel] = 1'b0; cont_i[sel] = 1'b0;
    endtask

    initial begin
        int per, oe, we, led;
        step_t tmp;
        Reset = 1'b1;
        cur_op = 4'd0; cur_ir5 = 1'b0; cur_ben = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_i[i] = 0; cont_i[i] = 0; op_i[i] = 0; ir5_i[i] = 0; ben_i[i] = 0;
        end
        @(posedge Clk); #1;
        chk_en = 1'b1;

        // Reset held with Run=0, then ADD-immediate on MEM_WAIT=2.
        repeat (10) push("HALT", 1'b0, 1'b0, 1'b1);
        halted(2);
        add_instr(2, 4'b0001, 1'b1, 1'b0, 0, 0);
        end_seq();
        play(0, per, oe, we, led);
        check("add_period", 32'(per), 32'd6);
        check("add_oe_low", 32'(oe), 32'd2);

        // Branch both ways, long pause, NOT, JMP, JSR.
        halted(1);
        add_instr(2, 4'b0000, 1'b0, 1'b0, 0, 0);
        add_instr(2, 4'b0000, 1'b0, 1'b1, 0, 0);
        add_instr(2, 4'b1101, 1'b0, 1'b0, 20, 5);
        add_instr(2, 4'b1001, 1'b0, 1'b0, 0, 0);
        add_instr(2, 4'b1100, 1'b1, 1'b0, 0, 0);
        add_instr(2, 4'b0100, 1'b0, 1'b0, 0, 0);
        end_seq();
        play(0, per, oe, we, led);
        check("pause_led_cnt", 32'(led), 32'd1);
        check("jsr_period", 32'(per), 32'd7);

        // Store on MEM_WAIT=3.
        halted(1);
        add_instr(3, 4'b0111, 1'b0, 1'b0, 0, 0);
        end_seq();
        play(1, per, oe, we, led);
        check("str_period", 32'(per), 32'd11);
        check("str_we_low", 32'(we), 32'd3);
        check("str_oe_low", 32'(oe), 32'd3);

        // Reset in the second S25 cycle of an LDR, then a full LDR.
        halted(1);
        add_instr(3, 4'b0110, 1'b0, 1'b0, 0, 0);
        tmp = q[mark + 1];
        tmp.rst = 1'b1;
        q[mark + 1] = tmp;
        while (q.size() > mark + 2) void'(q.pop_back());
        halted(2);
        add_instr(3, 4'b0110, 1'b1, 1'b1, 0, 0);
        end_seq();
        play(1, per, oe, we, led);
        check("ldr_period", 32'(per), 32'd11);

        // Random instruction streams on both instances.
        for (int sel = 0; sel < 2; sel++) begin
            halted(1);
            for (int k = 0; k < 40; k++)
                add_instr(sel + 2, 4'($urandom_range(15, 0)), rb(), rb(),
                          int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
            end_seq();
            play(sel, per, oe, we, led);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
